// File: rtl/riscv_core_mul_seq.sv
// ---------------------------------------------------------------------------
// riscv_core_mul_seq
//
// Iterative radix-4 multiplier sequencer for the M-extension execute stage.
// Each request's operands are converted to magnitudes. Two partial products
// per cycle are folded into a redundant sum/carry accumulator through one
// 128-bit 4:2 compressor. A final carry-propagate add and a conditional
// negation produce the 128-bit product. The requested 64-bit slice is then
// returned on a valid/ready handshake.
//
// Optional feature macro: RISCV_MUL_WORD_EN
//   When defined, i_mul_word=1 selects MULW. The operands are truncated to
//   32 bits, 16 iterations are run, and the result is sign-extended from bit
//   31. When the macro is undefined, i_mul_word is ignored.
//
// Ports
//   i_clk               clock, rising edge
//   i_rst_n             asynchronous active-low reset
//   i_mul_valid         request valid
//   o_mul_ready         sequencer idle, request can be accepted
//   i_mul_op [1:0]      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   i_mul_word          MULW request (only with RISCV_MUL_WORD_EN)
//   i_mul_rs1 [XLEN]    multiplicand
//   i_mul_rs2 [XLEN]    multiplier
//   i_mul_flush         abort any in-flight operation
//   o_mul_valid         result valid
//   i_mul_result_ready  consumer accepts the result
//   o_mul_result [XLEN] result
// ---------------------------------------------------------------------------

// 4:2 compressor: in1+in2+in3+in4+cin == out1+out2 (mod 2^W).
// out2 is already shifted into place. cout_o carries the weight-2^W bit
// that a wider chain would consume.
module riscv_core_mul_csa42 #(
    parameter int W = 128
) (
    input  logic [W-1:0] in1_i,
    input  logic [W-1:0] in2_i,
    input  logic [W-1:0] in3_i,
    input  logic [W-1:0] in4_i,
    input  logic         cin_i,
    output logic [W-1:0] out1_o,
    output logic [W-1:0] out2_o,
    output logic         cout_o
);
    logic [W-1:0] s1;
    logic [W-1:0] co;
    logic [W-1:0] ci;
    logic [W-2:0] carry_lo;

    always_comb begin
        s1       = in1_i ^ in2_i ^ in3_i;
        co       = (in1_i & in2_i) | (in1_i & in3_i) | (in2_i & in3_i);
        // The first-level carries ripple only one position, into the second level.
        ci       = {co[W-2:0], cin_i};
        out1_o   = s1 ^ in4_i ^ ci;
        carry_lo = (s1[W-2:0] & in4_i[W-2:0]) | (s1[W-2:0] & ci[W-2:0]) |
                   (in4_i[W-2:0] & ci[W-2:0]);
        out2_o   = {carry_lo, 1'b0};
        cout_o   = co[W-1];
    end
endmodule

module riscv_core_mul_seq #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_mul_valid,
    output logic            o_mul_ready,
    input  logic [1:0]      i_mul_op,
    input  logic            i_mul_word,
    input  logic [XLEN-1:0] i_mul_rs1,
    input  logic [XLEN-1:0] i_mul_rs2,
    input  logic            i_mul_flush,
    output logic            o_mul_valid,
    input  logic            i_mul_result_ready,
    output logic [XLEN-1:0] o_mul_result
);
    localparam int PW = 2 * XLEN;
    localparam int CW = $clog2(XLEN / 2) + 1;
    localparam logic [CW-1:0] N_FULL = CW'(XLEN / 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_ADD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_neg);
        // The magnitude of the most negative value is 2^(XLEN-1). It fits
        // because the result is read as unsigned.
        return is_neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [PW-1:0] cond_negate(input logic [PW-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic [1:0]      state_q,     state_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [PW-1:0]   mcand_q,     mcand_d;
    logic [XLEN-1:0] mplier_q,    mplier_d;
    logic [PW-1:0]   acc_sum_q,   acc_sum_d;
    logic [PW-1:0]   acc_carry_q, acc_carry_d;
    logic            neg_q,       neg_d;
    logic [1:0]      op_q,        op_d;
    logic [XLEN-1:0] result_q,    result_d;
    logic [CW-1:0]   n_term;

    logic [PW-1:0]   csa_out1;
    logic [PW-1:0]   csa_out2;
    logic            csa_cout_unused;
    logic [PW-1:0]   pp0;
    logic [PW-1:0]   pp1;
    logic [PW-1:0]   prod;

    logic [XLEN-1:0] rs1_eff;
    logic [XLEN-1:0] rs2_eff;
    logic            rs1_neg;
    logic            rs2_neg;

`ifdef RISCV_MUL_WORD_EN
    localparam logic [CW-1:0] N_WORD = CW'(XLEN / 4);
    logic word_q, word_d;
    assign n_term = word_q ? N_WORD : N_FULL;
`else
    logic unused_word;
    assign unused_word = i_mul_word;
    assign n_term      = N_FULL;
`endif

    // Both partial products for the current multiplier digit.
    assign pp0 = mcand_q & {PW{mplier_q[0]}};
    assign pp1 = (mcand_q << 1) & {PW{mplier_q[1]}};

    riscv_core_mul_csa42 #(.W(PW)) u_csa42 (
        .in1_i  (acc_sum_q),
        .in2_i  (acc_carry_q),
        .in3_i  (pp0),
        .in4_i  (pp1),
        .cin_i  (1'b0),
        .out1_o (csa_out1),
        .out2_o (csa_out2),
        .cout_o (csa_cout_unused)
    );

    assign prod = cond_negate(acc_sum_q + acc_carry_q, neg_q);

    // Operand conditioning. MUL and MULHU are unsigned. MULH signs both
    // operands and MULHSU signs rs1 only. MULW is handled unsigned because
    // the low 32 product bits do not depend on signedness.
    always_comb begin
        rs1_eff = i_mul_rs1;
        rs2_eff = i_mul_rs2;
        rs1_neg = (i_mul_op == 2'b01 || i_mul_op == 2'b10) && i_mul_rs1[XLEN-1];
        rs2_neg = (i_mul_op == 2'b01) && i_mul_rs2[XLEN-1];
`ifdef RISCV_MUL_WORD_EN
        if (i_mul_word) begin
            rs1_eff = {{(XLEN-32){1'b0}}, i_mul_rs1[31:0]};
            rs2_eff = {{(XLEN-32){1'b0}}, i_mul_rs2[31:0]};
            rs1_neg = 1'b0;
            rs2_neg = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_sum_d   = acc_sum_q;
        acc_carry_d = acc_carry_q;
        neg_d       = neg_q;
        op_d        = op_q;
        result_d    = result_q;
`ifdef RISCV_MUL_WORD_EN
        word_d      = word_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_mul_valid && !i_mul_flush) begin
                    mcand_d     = {{XLEN{1'b0}}, abs_val(rs1_eff, rs1_neg)};
                    mplier_d    = abs_val(rs2_eff, rs2_neg);
                    neg_d       = rs1_neg ^ rs2_neg;
                    op_d        = i_mul_op;
                    acc_sum_d   = '0;
                    acc_carry_d = '0;
                    cnt_d       = '0;
`ifdef RISCV_MUL_WORD_EN
                    word_d      = i_mul_word;
`endif
                    state_d     = S_ITER;
                end
            end
            S_ITER: begin
                // The terminal count is checked before an iteration, so the
                // counter reaches exactly n_term and never wraps.
                if (cnt_q == n_term) begin
                    state_d = S_ADD;
                end else begin
                    acc_sum_d   = csa_out1;
                    acc_carry_d = csa_out2;
                    mcand_d     = mcand_q << 2;
                    mplier_d    = mplier_q >> 2;
                    cnt_d       = cnt_q + 1'b1;
                end
            end
            S_ADD: begin
`ifdef RISCV_MUL_WORD_EN
                if (word_q)
                    result_d = {{(XLEN-32){prod[31]}}, prod[31:0]};
                else
`endif
                if (op_q == 2'b00)
                    result_d = prod[XLEN-1:0];
                else
                    result_d = prod[PW-1:XLEN];
                state_d = S_DONE;
            end
            default: begin
                if (i_mul_result_ready)
                    state_d = S_IDLE;
            end
        endcase
        if (i_mul_flush)
            state_d = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_sum_q   <= '0;
            acc_carry_q <= '0;
            neg_q       <= 1'b0;
            op_q        <= 2'b00;
            result_q    <= '0;
`ifdef RISCV_MUL_WORD_EN
            word_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_sum_q   <= acc_sum_d;
            acc_carry_q <= acc_carry_d;
            neg_q       <= neg_d;
            op_q        <= op_d;
            result_q    <= result_d;
`ifdef RISCV_MUL_WORD_EN
            word_q      <= word_d;
`endif
        end
    end

    assign o_mul_ready  = (state_q == S_IDLE);
    assign o_mul_valid  = (state_q == S_DONE);
    assign o_mul_result = result_q;

endmodule
